// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one adder step.
//   state_e  : sequencer states (idle, running through nibbles, result held).
package nibble_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/nibble_ripple_adder.sv
// Combinational 4-bit ripple-carry adder, one nibble step of the serial adder.
// Ports:
//   a4, b4 : nibble operands
//   cin    : carry into bit 0
//   s4     : nibble sum
//   cout   : carry out of bit 3
module nibble_ripple_adder
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic                cout
);

  logic c;

  always_comb begin
    c  = cin;
    s4 = '0;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s4[i] = a4[i] ^ b4[i] ^ c;
      c     = (a4[i] & b4[i]) | (c & (a4[i] ^ b4[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: processes 4 bits per clock, low nibble first, through a single
// shared 4-bit ripple adder. The inter-nibble carry is registered and fed back.
// Optional signed-overflow output is enabled by defining NIBBLE_ADD_OVF_EN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only when idle)
//   a, b, c_in          : operands and initial carry, captured at accept
//   out_valid, out_ready: result handshake (result held while out_valid)
//   sum, c_out          : registered result and final carry
//   overflow            : registered signed overflow (NIBBLE_ADD_OVF_EN only)
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_ADD_OVF_EN
  output logic             overflow,
`endif
  output logic             c_out
);

  localparam int unsigned NumSteps = WIDTH / NIBBLE_W;
  localparam int unsigned CntW     = $clog2(NumSteps);
  localparam logic [CntW-1:0] LastStep = CntW'(NumSteps - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            c_out_q, c_out_d;

  logic [NIBBLE_W-1:0] a4, b4, s4;
  logic                cout4;

`ifdef NIBBLE_ADD_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Select the operand nibbles addressed by the step counter.
  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int unsigned k = 0; k < NumSteps; k++) begin
      if (cnt_q == CntW'(k)) begin
        a4 = a_q[k*NIBBLE_W +: NIBBLE_W];
        b4 = b_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_ripple_adder u_adder (
    .a4   (a4),
    .b4   (b4),
    .cin  (carry_q),
    .s4   (s4),
    .cout (cout4)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef NIBBLE_ADD_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      StIdle: begin
`ifdef NIBBLE_ADD_OVF_EN
        ovf_d = 1'b0;
`endif
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StRun;
`ifdef NIBBLE_ADD_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end

      StRun: begin
        for (int unsigned k = 0; k < NumSteps; k++) begin
          if (cnt_q == CntW'(k)) begin
            sum_d[k*NIBBLE_W +: NIBBLE_W] = s4;
          end
        end
        carry_d = cout4;
        if (cnt_q == LastStep) begin
          // Counter stays at the last step; it is cleared again at the next accept.
          c_out_d = cout4;
          state_d = StDone;
`ifdef NIBBLE_ADD_OVF_EN
          // s4[3] is the result MSB being written this cycle.
          ovf_d = (a_msb_q == b_msb_q) && (s4[NIBBLE_W-1] != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef NIBBLE_ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16). Expected results are computed with plain
// integer arithmetic and queued at issue; a negedge monitor pops and compares at each result
// handshake and checks accept-to-valid latency.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          c_in = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  sum;
  logic          in_ready;
  logic          out_valid;
  logic          c_out;
`ifdef NIBBLE_ADD_OVF_EN
  logic          overflow;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_ADD_OVF_EN
    .overflow  (overflow),
`endif
    .c_out     (c_out)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  logic ov_prev = 1'b0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t        m;
    int unsigned t;
    int          ss;
    t   = int'(x) + int'(y) + int'(ci);
    ss  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    m.s = t[W-1:0];
    m.c = t[W];
    m.v = (ss > 32767) || (ss < -32768);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency on each out_valid rise, scoreboard compare at each result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc_cyc <= -1;
      ov_prev <= 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc <= cyc + 1;
      if (out_valid && !ov_prev) begin
        check("accept_before_valid", 32'(acc_cyc >= 0), 32'd1);
        if (acc_cyc >= 0) check("latency", 32'(cyc - acc_cyc), 32'd4);
        acc_cyc <= -1;
      end
      if (out_valid && out_ready) begin
        check("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.s));
          check("c_out", 32'(c_out), 32'(e.c));
`ifdef NIBBLE_ADD_OVF_EN
          check("overflow", 32'(overflow), 32'(e.v));
`endif
        end
      end
      ov_prev <= out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y, ci));
    tick();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    c_in     = 1'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int k = 0;
    bit done = 1'b0;
    while (!done && k < 60) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      done      = out_valid && out_ready;
      tick();
      k++;
    end
    out_ready = 1'b0;
    check("result_within_budget", 32'(done), 32'd1);
  endtask

  initial begin
    int k;
    bit seen;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);

    // Directed vectors.
    issue(16'h1234, 16'h4321, 1'b0); drain(1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1); drain(1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0); drain(1'b0);
    issue(16'h8000, 16'hFFFF, 1'b0); drain(1'b0);

    // Random vectors with random consumer back-pressure.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      drain(1'b1);
    end

    // Long back-pressure with input activity.
    issue(16'h1234, 16'h4321, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp_valid_reached", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a        = W'($urandom);
      tick();
      check("bp_sum_stable", 32'(sum), 32'h5555);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset after the second nibble of an operation.
    issue(16'hAAAA, 16'h5555, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_c_out", 32'(c_out), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
`ifdef NIBBLE_ADD_OVF_EN
    check("mid_rst_overflow", 32'(overflow), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("no_valid_after_abort", 32'(seen), 32'd0);
    issue(16'h0001, 16'h0001, 1'b0);
    drain(1'b0);

    repeat (2) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
